// File: rtl/output_display_scanner_if.sv
// ---------------------------------------------------------------------------
// output_display_scanner_if
// Bundle between the display-word producer and the 7-segment scanner.
//   DISP_IN          [16:10] raw sign segment pattern, [9:0] value field
//   HEXADECIMAL_FLAG 1 = value[7:0] is two hex nibbles, 0 = BCD digits
//   DISP_EN          0 = all digit anodes dark (scanning keeps running)
//   SEG_N            segments {g,f,e,d,c,b,a}, active-low
//   DIGIT_EN_N       digit anodes, active-low; bit0 ones .. bit3 sign
//   FRAME_DONE       one-cycle pulse at each frame start
// master = producer/board side, slave = scanner.
// ---------------------------------------------------------------------------
interface output_display_scanner_if;
    logic [16:0] DISP_IN;
    logic        HEXADECIMAL_FLAG;
    logic        DISP_EN;
    logic [6:0]  SEG_N;
    logic [3:0]  DIGIT_EN_N;
    logic        FRAME_DONE;

    modport master (
        output DISP_IN, HEXADECIMAL_FLAG, DISP_EN,
        input  SEG_N, DIGIT_EN_N, FRAME_DONE
    );

    modport slave (
        input  DISP_IN, HEXADECIMAL_FLAG, DISP_EN,
        output SEG_N, DIGIT_EN_N, FRAME_DONE
    );
endinterface

// File: rtl/output_display_scanner.sv
// ---------------------------------------------------------------------------
// output_display_scanner
// Time-multiplexes the 17-bit display word onto a 4-digit common-anode
// 7-segment display (ones, tens, hundreds, sign). The word is snapshotted
// once per frame so a frame never mixes two values.
//   CLK    system clock, rising edge
//   CLR_N  asynchronous active-low reset, released synchronously
//   bus    output_display_scanner_if.slave (see interface header)
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (>= 1)
//   BLANK_LZ  1 = blank leading zeros in decimal mode
// ---------------------------------------------------------------------------
module output_display_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                      CLK,
    input  logic                      CLR_N,
    output_display_scanner_if.slave   bus
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [16:0]      snap;
    logic             snap_hex;
    logic             run;       // set by the first tick; keeps anodes dark until then
    logic [6:0]       seg_q;
    logic [3:0]       en_q;
    logic             frame_q;

    logic        tick;
    logic        frame_start;
    logic [1:0]  idx_nxt;
    logic [16:0] src_word;
    logic        src_hex;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Segment pattern for slot k of word w. Nibbles above 9 in decimal mode
    // simply show their hex glyph.
    function automatic logic [6:0] slot_seg(input logic [1:0] k, input logic [16:0] w,
                                            input logic hex);
        logic [3:0] d1;
        logic [3:0] d2;
        logic       b1;
        logic       b2;
        logic [6:0] s;
        d1 = w[7:4];
        d2 = {2'b00, w[9:8]};
        if (hex) begin
            b2 = 1'b1;
            b1 = 1'b0;
        end else begin
            b2 = BLANK_LZ && (d2 == 4'd0);
            b1 = BLANK_LZ && (d2 == 4'd0) && (d1 == 4'd0);
        end
        case (k)
            2'd0:    s = glyph(w[3:0]);
            2'd1:    s = b1 ? SEG_OFF : glyph(d1);
            2'd2:    s = b2 ? SEG_OFF : glyph(d2);
            default: s = w[16:10];
        endcase
        return s;
    endfunction

    always_comb begin
        tick        = (cnt == CNT_LAST);
        frame_start = tick && (idx == 2'd3);
        idx_nxt     = tick ? idx + 2'd1 : idx;
        // On the frame edge digit 0 is decoded from the live word so it
        // matches what is being captured into the snapshot.
        src_word    = frame_start ? bus.DISP_IN : snap;
        src_hex     = frame_start ? bus.HEXADECIMAL_FLAG : snap_hex;
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            cnt      <= '0;
            idx      <= 2'd3;
            snap     <= {7'b1111111, 10'b0};
            snap_hex <= 1'b0;
            run      <= 1'b0;
            seg_q    <= SEG_OFF;
            en_q     <= 4'b1111;
            frame_q  <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            frame_q <= frame_start;
            if (tick) begin
                idx   <= idx_nxt;
                run   <= 1'b1;
                seg_q <= slot_seg(idx_nxt, src_word, src_hex);
            end
            if (frame_start) begin
                snap     <= bus.DISP_IN;
                snap_hex <= bus.HEXADECIMAL_FLAG;
            end
            // Anodes follow DISP_EN every edge, independent of the scan.
            en_q <= (bus.DISP_EN && (run || tick)) ? ~(4'b0001 << idx_nxt) : 4'b1111;
        end
    end

    assign bus.SEG_N      = seg_q;
    assign bus.DIGIT_EN_N = en_q;
    assign bus.FRAME_DONE = frame_q;

endmodule

// File: tb/tb_output_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_output_display_scanner
// Directed bench for output_display_scanner with SCAN_DIV = 4. Two DUTs run
// in lock-step from the same inputs: dut_a with BLANK_LZ = 1, dut_b with 0.
// ---------------------------------------------------------------------------
module tb_output_display_scanner;

    localparam int SD = 4;

    logic CLK = 1'b0;
    logic CLR_N;

    always #5 CLK = ~CLK;

    output_display_scanner_if ifa();
    output_display_scanner_if ifb();

    output_display_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_a (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .bus   (ifa.slave)
    );

    output_display_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_b (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .bus   (ifb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] sa [4];
    logic [6:0] sb [4];
    logic [3:0] ea [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [6:0] sign, input logic [9:0] val, input logic hex);
        ifa.DISP_IN          = {sign, val};
        ifb.DISP_IN          = {sign, val};
        ifa.HEXADECIMAL_FLAG = hex;
        ifb.HEXADECIMAL_FLAG = hex;
    endtask

    task automatic set_en(input logic en);
        ifa.DISP_EN = en;
        ifb.DISP_EN = en;
    endtask

    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step(1);
            seen = ifa.FRAME_DONE;
        end
        check("frame_wait", 32'(seen), 1);
    endtask

    // Leaves the bench just after the edge that enters slot 3.
    task automatic read_frame();
        wait_frame();
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step(SD);
            sa[k] = ifa.SEG_N;
            sb[k] = ifb.SEG_N;
            ea[k] = ifa.DIGIT_EN_N;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        CLR_N = 1'b1;
        set_in(7'b1111111, 10'd0, 1'b0);
        set_en(1'b1);
        #1 CLR_N = 1'b0;
        #2;
        check("rst_seg", 32'(ifa.SEG_N), 'b1111111);
        check("rst_en",  32'(ifa.DIGIT_EN_N), 'b1111);
        check("rst_fd",  32'(ifa.FRAME_DONE), 0);

        // Reset asserted mid-scan takes effect without a clock edge
        @(posedge CLK); #1 CLR_N = 1'b1;
        step(6);
        check("pre_async_en", 32'(ifa.DIGIT_EN_N), 'b1110);
        #2 CLR_N = 1'b0;
        #1;
        check("async_seg", 32'(ifa.SEG_N), 'b1111111);
        check("async_en",  32'(ifa.DIGIT_EN_N), 'b1111);
        check("async_fd",  32'(ifa.FRAME_DONE), 0);

        set_in(7'b1010100, 10'b01_0010_0111, 1'b0);
        @(posedge CLK); #1 CLR_N = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step(1);
            check("rel_en_dark", 32'(ifa.DIGIT_EN_N), 'b1111);
            check("rel_fd_low",  32'(ifa.FRAME_DONE), 0);
        end
        step(1);
        check("rel_edge4_en",  32'(ifa.DIGIT_EN_N), 'b1110);
        check("rel_edge4_fd",  32'(ifa.FRAME_DONE), 1);
        check("rel_edge4_seg", 32'(ifa.SEG_N), 'b1111000);
        step(1);
        check("rel_fd_pulse", 32'(ifa.FRAME_DONE), 0);

        // Decimal 127
        read_frame();
        check("d127_d0", 32'(sa[0]), 'b1111000);
        check("d127_d1", 32'(sa[1]), 'b0100100);
        check("d127_d2", 32'(sa[2]), 'b1111001);
        check("d127_d3", 32'(sa[3]), 'b1010100);
        check("d127_e0", 32'(ea[0]), 'b1110);
        check("d127_e1", 32'(ea[1]), 'b1101);
        check("d127_e2", 32'(ea[2]), 'b1011);
        check("d127_e3", 32'(ea[3]), 'b0111);

        // Leading-zero blanking
        set_in(7'b1111111, 10'b00_0000_0101, 1'b0);
        read_frame();
        check("d005_d0",   32'(sa[0]), 'b0010010);
        check("d005_d1",   32'(sa[1]), 'b1111111);
        check("d005_d2",   32'(sa[2]), 'b1111111);
        check("d005_e1",   32'(ea[1]), 'b1101);
        check("d005_nb_d0", 32'(sb[0]), 'b0010010);
        check("d005_nb_d1", 32'(sb[1]), 'b1000000);
        check("d005_nb_d2", 32'(sb[2]), 'b1000000);

        set_in(7'b1111111, 10'b00_0000_0000, 1'b0);
        read_frame();
        check("d000_d0", 32'(sa[0]), 'b1000000);
        check("d000_d1", 32'(sa[1]), 'b1111111);
        check("d000_d2", 32'(sa[2]), 'b1111111);
        check("d000_d3", 32'(sa[3]), 'b1111111);

        set_in(7'b1111111, 10'b01_0000_0000, 1'b0);
        read_frame();
        check("d100_d0", 32'(sa[0]), 'b1000000);
        check("d100_d1", 32'(sa[1]), 'b1000000);
        check("d100_d2", 32'(sa[2]), 'b1111001);

        // Hex mode
        set_in(7'b1011000, 10'b00_1010_1111, 1'b1);
        read_frame();
        check("hxAF_d0", 32'(sa[0]), 'b0001110);
        check("hxAF_d1", 32'(sa[1]), 'b0001000);
        check("hxAF_d2", 32'(sa[2]), 'b1111111);
        check("hxAF_d3", 32'(sa[3]), 'b1011000);
        check("hxAF_nb_d2", 32'(sb[2]), 'b1111111);

        set_in(7'b1111111, 10'b11_0000_0000, 1'b1);
        read_frame();
        check("hx300_d0", 32'(sa[0]), 'b1000000);
        check("hx300_d1", 32'(sa[1]), 'b1000000);
        check("hx300_d2", 32'(sa[2]), 'b1111111);

        // Tear-free snapshot and frame period
        set_in(7'b1010100, 10'b01_0010_0111, 1'b0);
        wait_frame();
        check("tear_d0", 32'(ifa.SEG_N), 'b1111000);
        step(SD);
        check("tear_d1", 32'(ifa.SEG_N), 'b0100100);
        set_in(7'b1111111, 10'b00_0000_0101, 1'b0);
        step(SD);
        check("tear_d2", 32'(ifa.SEG_N), 'b1111001);
        step(SD);
        check("tear_d3", 32'(ifa.SEG_N), 'b1010100);
        step(SD - 1);
        check("period_early", 32'(ifa.FRAME_DONE), 0);
        step(1);
        check("period_fd",  32'(ifa.FRAME_DONE), 1);
        check("new_d0",     32'(ifa.SEG_N), 'b0010010);
        step(SD);
        check("new_d1",     32'(ifa.SEG_N), 'b1111111);
        step(SD);
        check("new_d2",     32'(ifa.SEG_N), 'b1111111);
        step(SD);
        check("new_d3",     32'(ifa.SEG_N), 'b1111111);

        // DISP_EN low for 10 sampled edges spanning a frame boundary
        wait_frame();
        step(8);
        set_en(1'b0);
        for (int k = 9; k <= 18; k++) begin
            step(1);
            check("dis_en", 32'(ifa.DIGIT_EN_N), 'b1111);
            check("dis_fd", 32'(ifa.FRAME_DONE), (k == 16) ? 1 : 0);
        end
        set_en(1'b1);
        step(1);
        check("reen_en_d0", 32'(ifa.DIGIT_EN_N), 'b1110);
        step(1);
        check("reen_en_d1", 32'(ifa.DIGIT_EN_N), 'b1101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
